// File: rtl/fusion_frame_sequencer.sv
// Frame-level sequencer for the multi-frame fusion datapath: drives handshakes, pipeline
// enables, avg/fused BRAM addressing and the fusion-window position.
module fusion_frame_sequencer #(
    parameter int IM_LEN            = 520,
    parameter int IM_WID            = 520,
    parameter int NO_PARALLEL_UNITS = 4,
    parameter int NO_IMAGES         = 16,
    parameter int PIPELINE_LATENCY  = 20,
    parameter int BEATS             = IM_LEN * IM_WID / NO_PARALLEL_UNITS,
    parameter int AW                = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic          axi_clk,
    input  logic          axi_aresetn,
    input  logic          start,
    input  logic          s_axis_tvalid,
    output logic          s_axis_tready,
    input  logic          m_axis_tready,
    output logic          m_axis_tvalid,
    output logic          m_axis_tlast,
    output logic          pipe_en,
    output logic          bram_rd_en,
    output logic [AW-1:0] bram_rd_addr,
    output logic          bram_wr_en,
    output logic [AW-1:0] bram_wr_addr,
    output logic          fuse_writeout,
    output logic [3:0]    frame_idx,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam logic [AW-1:0] LAST_BEAT  = AW'(BEATS - 1);
    localparam logic [3:0]    LAST_FRAME = 4'(NO_IMAGES - 1);

    state_t                      state_reg, state_next;
    logic [AW-1:0]               in_cnt_reg, out_cnt_reg;
    logic [PIPELINE_LATENCY-1:0] valid_sr_reg, valid_sr_next;
    logic [3:0]                  frame_idx_reg;
    logic                        fuse_reg, done_reg;
    logic                        in_hs, out_hs, frame_start, frame_end;

    assign s_axis_tready = (state_reg == RUN) & m_axis_tready;
    assign m_axis_tvalid = valid_sr_reg[PIPELINE_LATENCY-1];
    assign in_hs         = s_axis_tvalid & s_axis_tready;
    assign out_hs        = m_axis_tvalid & m_axis_tready;
    assign frame_start   = (state_reg == IDLE) & start;
    assign frame_end     = (state_reg == DRAIN) & out_hs & (out_cnt_reg == LAST_BEAT);

    // Valid tokens travel alongside the datapath and advance only when it is enabled.
    assign valid_sr_next[0] = in_hs;
    for (genvar gi = 1; gi < PIPELINE_LATENCY; gi++) begin : g_valid_pipe
        assign valid_sr_next[gi] = valid_sr_reg[gi-1];
    end

    always_comb begin
        state_next = state_reg;
        pipe_en    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) state_next = RUN;
            end
            RUN: begin
                pipe_en = s_axis_tvalid & m_axis_tready;
                if (in_hs && (in_cnt_reg == LAST_BEAT)) state_next = DRAIN;
            end
            DRAIN: begin
                pipe_en = m_axis_tready;
                if (frame_end) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge axi_clk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_reg     <= IDLE;
            in_cnt_reg    <= '0;
            out_cnt_reg   <= '0;
            valid_sr_reg  <= '0;
            frame_idx_reg <= '0;
            fuse_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= frame_end;
            if (pipe_en) valid_sr_reg <= valid_sr_next;
            if (frame_start) begin
                in_cnt_reg  <= '0;
                out_cnt_reg <= '0;
                fuse_reg    <= (frame_idx_reg == LAST_FRAME);
            end else begin
                if (in_hs)  in_cnt_reg  <= in_cnt_reg + 1'b1;
                if (out_hs) out_cnt_reg <= out_cnt_reg + 1'b1;
            end
            // Window position advances once the frame's last fused beat has left.
            if (frame_end) begin
                frame_idx_reg <= (frame_idx_reg == LAST_FRAME) ? 4'd0 : frame_idx_reg + 4'd1;
                fuse_reg      <= 1'b0;
            end
        end
    end

    assign m_axis_tlast  = m_axis_tvalid & (out_cnt_reg == LAST_BEAT);
    assign bram_rd_en    = in_hs;
    assign bram_rd_addr  = in_cnt_reg;
    assign bram_wr_en    = out_hs;
    assign bram_wr_addr  = out_cnt_reg;
    assign fuse_writeout = fuse_reg;
    assign frame_idx     = frame_idx_reg;
    assign busy          = (state_reg != IDLE);
    assign done          = done_reg;

endmodule

// File: tb/tb_fusion_frame_sequencer.sv
// Scoreboard bench for fusion_frame_sequencer at BEATS=4, PIPELINE_LATENCY=3.
module tb_fusion_frame_sequencer;

    localparam int AW = 2;

    logic          axi_clk = 1'b0;
    logic          axi_aresetn = 1'b0;
    logic          start = 1'b0;
    logic          s_axis_tvalid = 1'b0;
    logic          m_axis_tready = 1'b0;
    logic          s_axis_tready, m_axis_tvalid, m_axis_tlast, pipe_en;
    logic          bram_rd_en, bram_wr_en, fuse_writeout, busy, done;
    logic [AW-1:0] bram_rd_addr, bram_wr_addr;
    logic [3:0]    frame_idx;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          last;
        logic          fuse;
    } out_rec_t;

    out_rec_t      out_q[$];
    logic [AW-1:0] in_q[$];
    logic [3:0]    done_q[$];
    out_rec_t      mon_rec;
    logic [AW-1:0] mon_rd;
    logic [3:0]    mon_idx;
    int            n_pass = 0;
    int            n_total = 0;
    int            exp_idx = 0;

    always #5 axi_clk = ~axi_clk;

    fusion_frame_sequencer #(
        .IM_LEN(4), .IM_WID(4), .NO_PARALLEL_UNITS(4), .NO_IMAGES(16), .PIPELINE_LATENCY(3)
    ) dut (
        .axi_clk(axi_clk), .axi_aresetn(axi_aresetn), .start(start),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .m_axis_tready(m_axis_tready), .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
        .pipe_en(pipe_en), .bram_rd_en(bram_rd_en), .bram_rd_addr(bram_rd_addr),
        .bram_wr_en(bram_wr_en), .bram_wr_addr(bram_wr_addr), .fuse_writeout(fuse_writeout),
        .frame_idx(frame_idx), .busy(busy), .done(done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Monitor: pops expected records whenever the DUT presents a read, an output beat or done.
    always @(negedge axi_clk) begin
        if (axi_aresetn) begin
            if (bram_rd_en) begin
                check("rd_expected", 32'(in_q.size() != 0), 1);
                if (in_q.size() != 0) begin
                    mon_rd = in_q.pop_front();
                    check("rd_addr", 32'(bram_rd_addr), 32'(mon_rd));
                end
            end
            if (m_axis_tvalid && m_axis_tready) begin
                check("beat_expected", 32'(out_q.size() != 0), 1);
                if (out_q.size() != 0) begin
                    mon_rec = out_q.pop_front();
                    check("wr_en", 32'(bram_wr_en), 1);
                    check("wr_addr", 32'(bram_wr_addr), 32'(mon_rec.addr));
                    check("tlast", 32'(m_axis_tlast), 32'(mon_rec.last));
                    check("fuse_writeout", 32'(fuse_writeout), 32'(mon_rec.fuse));
                end
            end
            if (done) begin
                check("done_expected", 32'(done_q.size() != 0), 1);
                if (done_q.size() != 0) begin
                    mon_idx = done_q.pop_front();
                    check("frame_idx_at_done", 32'(frame_idx), 32'(mon_idx));
                end
            end
        end
    end

    task automatic check_zero(input string tag);
        check({tag, "_state_busy"}, 32'(busy), 0);
        check({tag, "_s_tready"}, 32'(s_axis_tready), 0);
        check({tag, "_m_tvalid"}, 32'(m_axis_tvalid), 0);
        check({tag, "_m_tlast"}, 32'(m_axis_tlast), 0);
        check({tag, "_pipe_en"}, 32'(pipe_en), 0);
        check({tag, "_rd_en"}, 32'(bram_rd_en), 0);
        check({tag, "_rd_addr"}, 32'(bram_rd_addr), 0);
        check({tag, "_wr_en"}, 32'(bram_wr_en), 0);
        check({tag, "_wr_addr"}, 32'(bram_wr_addr), 0);
        check({tag, "_fuse"}, 32'(fuse_writeout), 0);
        check({tag, "_frame_idx"}, 32'(frame_idx), 0);
        check({tag, "_done"}, 32'(done), 0);
    endtask

    // Called at posedge+1 with the DUT idle. Pattern bit c applies to RUN cycle c (cycle 0 is
    // the first cycle after start); tr/tv/pe are expected tready/tvalid/pipe_en per cycle.
    task automatic run_frame(input string tag, input logic [31:0] sv_pat, input logic [31:0] mr_pat,
                             input logic [31:0] st_pat, input bit trace, input logic [31:0] tr_pat,
                             input logic [31:0] tv_pat, input logic [31:0] pe_pat);
        int c;
        bit got;
        out_rec_t r;
        for (int i = 0; i < 4; i++) begin
            in_q.push_back(AW'(i));
            r.addr = AW'(i);
            r.last = (i == 3);
            r.fuse = (exp_idx == 15);
            out_q.push_back(r);
        end
        done_q.push_back(4'((exp_idx + 1) % 16));
        start = 1'b1; s_axis_tvalid = 1'b0; m_axis_tready = 1'b1;
        @(posedge axi_clk); #1;
        start = 1'b0;
        c = 0; got = 1'b0;
        while (!got && c < 30) begin
            s_axis_tvalid = sv_pat[c]; m_axis_tready = mr_pat[c]; start = st_pat[c];
            @(negedge axi_clk);
            if (c == 0) check({tag, "_fuse_run"}, 32'(fuse_writeout), 32'(exp_idx == 15));
            if (trace) begin
                check($sformatf("%s_tready_c%0d", tag, c), 32'(s_axis_tready), 32'(tr_pat[c]));
                check($sformatf("%s_tvalid_c%0d", tag, c), 32'(m_axis_tvalid), 32'(tv_pat[c]));
                check($sformatf("%s_pipe_en_c%0d", tag, c), 32'(pipe_en), 32'(pe_pat[c]));
            end
            got = done;
            @(posedge axi_clk); #1;
            c++;
        end
        start = 1'b0; s_axis_tvalid = 1'b0; m_axis_tready = 1'b1;
        check({tag, "_done_seen"}, 32'(got), 1);
        @(negedge axi_clk);
        check({tag, "_done_width"}, 32'(done), 0);
        check({tag, "_idle"}, 32'(busy), 0);
        check({tag, "_fuse_idle"}, 32'(fuse_writeout), 0);
        @(posedge axi_clk); #1;
        exp_idx = (exp_idx + 1) % 16;
        check({tag, "_drained"}, 32'(out_q.size() + in_q.size() + done_q.size()), 0);
        out_q.delete(); in_q.delete(); done_q.delete();
        $display("frame %s complete, frame_idx=%0d", tag, frame_idx);
    endtask

    initial begin
        #2;
        check_zero("por");
        repeat (2) @(posedge axi_clk);
        #1 axi_aresetn = 1'b1;
        @(posedge axi_clk); #1;

        run_frame("stream", '1, '1, '0, 1'b1, 32'h0F, 32'h78, 32'h7F);
        run_frame("backpressure", '1, ~32'h18, '0, 1'b1, 32'h27, 32'h1F8, 32'h1E7);
        run_frame("ignored_start", '1, '1, 32'h22, 1'b1, 32'h0F, 32'h78, 32'h7F);
        run_frame("input_gaps", 32'h35, '1, '0, 1'b1, 32'h3F, 32'h1E0, 32'h1F5);
        check("pre_reset_frame_idx", 32'(frame_idx), 4);

        // Abort a frame after two accepted beats.
        in_q.push_back(AW'(0));
        in_q.push_back(AW'(1));
        start = 1'b1;
        @(posedge axi_clk); #1;
        start = 1'b0; s_axis_tvalid = 1'b1; m_axis_tready = 1'b1;
        repeat (2) @(posedge axi_clk);
        #1;
        check("mid_reset_two_reads", 32'(in_q.size()), 0);
        axi_aresetn = 1'b0;
        #1;
        check_zero("mid_reset");
        s_axis_tvalid = 1'b0;
        in_q.delete(); out_q.delete(); done_q.delete();
        repeat (2) @(posedge axi_clk);
        #1 axi_aresetn = 1'b1;
        s_axis_tvalid = 1'b1;
        @(negedge axi_clk);
        check("no_resume_busy", 32'(busy), 0);
        check("no_resume_tready", 32'(s_axis_tready), 0);
        check("no_resume_rd_en", 32'(bram_rd_en), 0);
        @(posedge axi_clk); #1;
        s_axis_tvalid = 1'b0;
        exp_idx = 0;
        $display("mid-frame reset applied, frame_idx=%0d", frame_idx);

        for (int f = 0; f < 16; f++)
            run_frame($sformatf("window%0d", f), '1, '1, '0, 1'b0, '0, '0, '0);
        check("window_wrap_frame_idx", 32'(frame_idx), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
